// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter that shares one fp_unit datapath between NREQ requesters.
// One operation is in flight at a time. Operands stay latched until the unit reports
// ready, and a watchdog turns a hung operation into a timeout response.
// Per-requester sticky exception flags are kept for fcsr.
module fp_unit_arbiter #(
    parameter int NREQ    = 2,
    parameter int OPW     = 24,
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*64-1:0]  req_data1,
    input  logic [NREQ*64-1:0]  req_data2,
    input  logic [NREQ*64-1:0]  req_data3,
    input  logic [NREQ*2-1:0]   req_fmt,
    input  logic [NREQ*3-1:0]   req_rm,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic                exe_enable,
    output logic [63:0]         exe_data1,
    output logic [63:0]         exe_data2,
    output logic [63:0]         exe_data3,
    output logic [1:0]          exe_fmt,
    output logic [2:0]          exe_rm,
    output logic [OPW-1:0]      exe_op,
    input  logic [63:0]         exe_result,
    input  logic [4:0]          exe_flags,
    input  logic                exe_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [63:0]         rsp_result,
    output logic [4:0]          rsp_flags,
    output logic                rsp_timeout,
    output logic [NREQ*5-1:0]   fflags_acc,
    input  logic [NREQ-1:0]     fflags_clr,
    output logic                busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_last_grant;
    logic [CW-1:0]   r_count;
    logic            r_exe_enable;
    logic [63:0]     r_exe_data1;
    logic [63:0]     r_exe_data2;
    logic [63:0]     r_exe_data3;
    logic [1:0]      r_exe_fmt;
    logic [2:0]      r_exe_rm;
    logic [OPW-1:0]  r_exe_op;
    logic [NREQ-1:0] r_rsp_valid;
    logic [63:0]     r_rsp_result;
    logic [4:0]      r_rsp_flags;
    logic            r_rsp_timeout;
    logic            r_busy;

    logic [63:0]     w_slice_data1 [NREQ];
    logic [63:0]     w_slice_data2 [NREQ];
    logic [63:0]     w_slice_data3 [NREQ];
    logic [1:0]      w_slice_fmt   [NREQ];
    logic [2:0]      w_slice_rm    [NREQ];
    logic [OPW-1:0]  w_slice_op    [NREQ];

    logic            w_any;
    logic [IW-1:0]   w_cand;
    logic [IW-1:0]   w_grant_idx;
    logic [NREQ-1:0] w_grant_onehot;
    logic [NREQ-1:0] w_last_onehot;

    // Per-requester operand slices and sticky flag accumulators
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            logic [4:0] r_fflags;

            assign w_slice_data1[gi] = req_data1[64*gi +: 64];
            assign w_slice_data2[gi] = req_data2[64*gi +: 64];
            assign w_slice_data3[gi] = req_data3[64*gi +: 64];
            assign w_slice_fmt[gi]   = req_fmt[2*gi +: 2];
            assign w_slice_rm[gi]    = req_rm[3*gi +: 3];
            assign w_slice_op[gi]    = req_op[OPW*gi +: OPW];
            assign fflags_acc[5*gi +: 5] = r_fflags;

            // Sticky OR of response flags; a coincident clear drops only the old value
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_fflags <= '0;
                end else if (r_rsp_valid[gi]) begin
                    r_fflags <= (fflags_clr[gi] ? 5'd0 : r_fflags) | r_rsp_flags;
                end else if (fflags_clr[gi]) begin
                    r_fflags <= '0;
                end
            end
        end
    endgenerate

    // Round-robin pick: first pending requester after the last grant, wrapping.
    // Scanning farthest-first and overwriting leaves the nearest candidate.
    always_comb begin
        w_any       = 1'b0;
        w_cand      = '0;
        w_grant_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IW'((int'(r_last_grant) + k) % NREQ);
            if (req_valid[w_cand]) begin
                w_grant_idx = w_cand;
                w_any       = 1'b1;
            end
        end
    end

    // One-hot forms of the new grant and of the operation in flight
    always_comb begin
        w_grant_onehot              = '0;
        w_grant_onehot[w_grant_idx] = w_any;
        w_last_onehot               = '0;
        w_last_onehot[r_last_grant] = 1'b1;
    end

    assign req_ready   = (r_state == IDLE && !reset) ? w_grant_onehot : '0;
    assign exe_enable  = r_exe_enable;
    assign exe_data1   = r_exe_data1;
    assign exe_data2   = r_exe_data2;
    assign exe_data3   = r_exe_data3;
    assign exe_fmt     = r_exe_fmt;
    assign exe_rm      = r_exe_rm;
    assign exe_op      = r_exe_op;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_flags   = r_rsp_flags;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = r_busy;

    // Control FSM: accept, launch, wait with watchdog, respond
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_grant  <= IW'(NREQ - 1);
            r_count       <= '0;
            r_exe_enable  <= 1'b0;
            r_exe_data1   <= '0;
            r_exe_data2   <= '0;
            r_exe_data3   <= '0;
            r_exe_fmt     <= '0;
            r_exe_rm      <= '0;
            r_exe_op      <= '0;
            r_rsp_valid   <= '0;
            r_rsp_result  <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_exe_enable <= 1'b0;
            r_rsp_valid  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_exe_data1  <= w_slice_data1[w_grant_idx];
                        r_exe_data2  <= w_slice_data2[w_grant_idx];
                        r_exe_data3  <= w_slice_data3[w_grant_idx];
                        r_exe_fmt    <= w_slice_fmt[w_grant_idx];
                        r_exe_rm     <= w_slice_rm[w_grant_idx];
                        r_exe_op     <= w_slice_op[w_grant_idx];
                        r_last_grant <= w_grant_idx;
                        r_exe_enable <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_count <= '0;
                    if (exe_ready) begin
                        r_rsp_result  <= exe_result;
                        r_rsp_flags   <= exe_flags;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= w_last_onehot;
                        r_state       <= RESP;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (exe_ready) begin
                        r_rsp_result  <= exe_result;
                        r_rsp_flags   <= exe_flags;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= w_last_onehot;
                        r_state       <= RESP;
                    end else if (r_count == CW'(TIMEOUT - 1)) begin
                        r_rsp_result  <= '0;
                        r_rsp_flags   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= w_last_onehot;
                        r_state       <= RESP;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: the bench plays both the requesters and the fp_unit,
// and predicts grant, response cycle, payload and sticky flags at transaction level.
module tb_fp_unit_arbiter;

    localparam int NREQ    = 2;
    localparam int OPW     = 24;
    localparam int TIMEOUT = 24;

    logic                clock;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*64-1:0]  req_data1;
    logic [NREQ*64-1:0]  req_data2;
    logic [NREQ*64-1:0]  req_data3;
    logic [NREQ*2-1:0]   req_fmt;
    logic [NREQ*3-1:0]   req_rm;
    logic [NREQ*OPW-1:0] req_op;
    logic                exe_enable;
    logic [63:0]         exe_data1;
    logic [63:0]         exe_data2;
    logic [63:0]         exe_data3;
    logic [1:0]          exe_fmt;
    logic [2:0]          exe_rm;
    logic [OPW-1:0]      exe_op;
    logic [63:0]         exe_result;
    logic [4:0]          exe_flags;
    logic                exe_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic [63:0]         rsp_result;
    logic [4:0]          rsp_flags;
    logic                rsp_timeout;
    logic [NREQ*5-1:0]   fflags_acc;
    logic [NREQ-1:0]     fflags_clr;
    logic                busy;

    // Per-requester operation contents presented on the packed request buses
    logic [63:0]    d1  [NREQ];
    logic [63:0]    d2  [NREQ];
    logic [63:0]    d3  [NREQ];
    logic [1:0]     dfm [NREQ];
    logic [2:0]     drm [NREQ];
    logic [OPW-1:0] dop [NREQ];

    // Reference state: last granted requester and expected sticky flags
    int         m_last;
    logic [4:0] m_acc [NREQ];

    int n_checks;
    int n_errors;
    int cyc;
    int n_txn;

    fp_unit_arbiter #(
        .NREQ(NREQ), .OPW(OPW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
        .req_fmt(req_fmt), .req_rm(req_rm), .req_op(req_op),
        .exe_enable(exe_enable),
        .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_data3(exe_data3),
        .exe_fmt(exe_fmt), .exe_rm(exe_rm), .exe_op(exe_op),
        .exe_result(exe_result), .exe_flags(exe_flags), .exe_ready(exe_ready),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_timeout(rsp_timeout), .fflags_acc(fflags_acc),
        .fflags_clr(fflags_clr), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pack the per-requester operations onto the request buses
    always_comb begin
        req_data1 = '0;
        req_data2 = '0;
        req_data3 = '0;
        req_fmt   = '0;
        req_rm    = '0;
        req_op    = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data1[64*i +: 64]  = d1[i];
            req_data2[64*i +: 64]  = d2[i];
            req_data3[64*i +: 64]  = d3[i];
            req_fmt[2*i +: 2]      = dfm[i];
            req_rm[3*i +: 3]       = drm[i];
            req_op[OPW*i +: OPW]   = dop[i];
        end
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [NREQ*5-1:0] pack_acc();
        logic [NREQ*5-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) v[5*i +: 5] = m_acc[i];
        return v;
    endfunction

    task automatic model_reset();
        m_last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) m_acc[i] = '0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) begin
            d1[i]  = {$urandom, $urandom};
            d2[i]  = {$urandom, $urandom};
            d3[i]  = {$urandom, $urandom};
            dfm[i] = 2'($urandom);
            drm[i] = 3'($urandom);
            dop[i] = OPW'($urandom);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic pulse_clr(input logic [NREQ-1:0] mask);
        fflags_clr = mask;
        tick();
        fflags_clr = '0;
        #1;
        for (int i = 0; i < NREQ; i++) if (mask[i]) m_acc[i] = '0;
        check_val("acc_after_clr", 256'(fflags_acc), 256'(pack_acc()));
    endtask

    // One full operation: present requests (mask), fp_unit answers lat cycles after the
    // enable cycle (lat<0: never), clr_at_resp is driven on fflags_clr in the response cycle.
    task automatic do_txn(input logic [NREQ-1:0] mask, input int lat, input logic [63:0] res,
                          input logic [4:0] flg, input logic [NREQ-1:0] clr_at_resp);
        int g;
        int t_acc;
        int e_cyc;
        int rdy_cyc;
        bit found;
        bit timed_out;
        logic [220:0] exp_exe;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (mask[idx] && g < 0) g = idx;
        end
        req_valid = mask;
        #1;
        found = 1'b0;
        for (int w = 0; w < 8; w++) begin
            if (req_ready != '0) begin
                found = 1'b1;
                break;
            end
            tick();
            #1;
        end
        check_val("grant", 256'(req_ready), 256'(oh(g)));
        if (!found) begin
            req_valid = '0;
            return;
        end
        t_acc     = cyc;
        m_last    = g;
        exp_exe   = {d1[g], d2[g], d3[g], dfm[g], drm[g], dop[g]};
        timed_out = (lat < 0) || (lat > TIMEOUT);
        rdy_cyc   = (lat < 0) ? -1 : t_acc + 1 + lat;
        e_cyc     = t_acc + 2 + (timed_out ? TIMEOUT : lat);
        while (cyc < e_cyc) begin
            tick();
            req_valid  = mask & ~oh(g);
            exe_ready  = (cyc == rdy_cyc);
            exe_result = exe_ready ? res : {$urandom, $urandom};
            exe_flags  = exe_ready ? flg : 5'($urandom);
            fflags_clr = (cyc == e_cyc) ? clr_at_resp : '0;
            #1;
            check_val("exe_enable", 256'(exe_enable), 256'(cyc == t_acc + 1));
            check_val("exe_bundle", 256'({exe_data1, exe_data2, exe_data3, exe_fmt, exe_rm, exe_op}),
                      256'(exp_exe));
            check_val("ready_quiet", 256'(req_ready), 256'(0));
            check_val("busy_active", 256'(busy), 256'(1));
            if (cyc < e_cyc) begin
                check_val("rsp_early", 256'(rsp_valid), 256'(0));
            end else begin
                check_val("rsp_valid", 256'(rsp_valid), 256'(oh(g)));
                check_val("rsp_result", 256'(rsp_result), 256'(timed_out ? 64'd0 : res));
                check_val("rsp_flags", 256'(rsp_flags), 256'(timed_out ? 5'd0 : flg));
                check_val("rsp_timeout", 256'(rsp_timeout), 256'(timed_out));
            end
        end
        for (int i = 0; i < NREQ; i++) if (clr_at_resp[i]) m_acc[i] = '0;
        if (!timed_out) m_acc[g] = m_acc[g] | flg;
        tick();
        req_valid  = '0;
        fflags_clr = '0;
        exe_ready  = (cyc == rdy_cyc);
        exe_result = {$urandom, $urandom};
        exe_flags  = 5'($urandom);
        #1;
        check_val("busy_idle", 256'(busy), 256'(0));
        check_val("rsp_once", 256'(rsp_valid), 256'(0));
        check_val("fflags_acc", 256'(fflags_acc), 256'(pack_acc()));
        if (rdy_cyc > e_cyc) begin
            while (cyc <= rdy_cyc) begin
                tick();
                exe_ready = (cyc == rdy_cyc);
                #1;
                check_val("late_ready_rsp", 256'(rsp_valid), 256'(0));
                check_val("late_ready_busy", 256'(busy), 256'(0));
            end
        end
        exe_ready = 1'b0;
        n_txn++;
        $display("txn %0d: req %0d lat %0d timeout %0b result %h flags %b", n_txn, g, lat,
                 timed_out, rsp_result, rsp_flags);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        int lat;
        logic [NREQ-1:0] mask;
        logic [NREQ-1:0] clr;
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        n_txn      = 0;
        reset      = 1'b1;
        req_valid  = '0;
        exe_result = '0;
        exe_flags  = '0;
        exe_ready  = 1'b0;
        fflags_clr = '0;
        rand_data();
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check_val("rst_req_ready", 256'(req_ready), 256'(0));
        check_val("rst_exe_enable", 256'(exe_enable), 256'(0));
        check_val("rst_exe_bundle", 256'({exe_data1, exe_data2, exe_data3, exe_fmt, exe_rm, exe_op}), 256'(0));
        check_val("rst_rsp", 256'({rsp_valid, rsp_result, rsp_flags, rsp_timeout}), 256'(0));
        check_val("rst_acc", 256'(fflags_acc), 256'(0));
        check_val("rst_busy", 256'(busy), 256'(0));

        // Only requester 1 pending after reset: granted at once
        do_txn(2'b10, 0, 64'h0123_4567_89AB_CDEF, 5'b00000, '0);

        // Single fadd from requester 0, unit ready one cycle after the enable
        do_reset();
        rand_data();
        d1[0]  = 64'h3F80_0000;
        d2[0]  = 64'h4000_0000;
        d3[0]  = 64'h0;
        dfm[0] = 2'd0;
        drm[0] = 3'd0;
        do_txn(2'b01, 1, 64'h4040_0000, 5'b00000, '0);

        // Round-robin with both requesters pending
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rand_data();
            do_txn(2'b11, k, {$urandom, $urandom}, 5'b00000, '0);
        end

        // Sticky flags, including a long fdiv from requester 1
        pulse_clr(2'b11);
        rand_data();
        do_txn(2'b01, 2, {$urandom, $urandom}, 5'b00100, '0);
        rand_data();
        d1[1] = 64'h3F80_0000;
        d2[1] = 64'h4040_0000;
        do_txn(2'b10, 20, 64'h3EAA_AAAB, 5'b00001, '0);
        rand_data();
        do_txn(2'b10, 3, {$urandom, $urandom}, 5'b10000, '0);
        check_val("sticky_req1", 256'(fflags_acc[9:5]), 256'(5'b10001));
        check_val("sticky_req0", 256'(fflags_acc[4:0]), 256'(5'b00100));
        pulse_clr(2'b10);
        check_val("clr_req1", 256'(fflags_acc[9:5]), 256'(5'b00000));
        check_val("clr_keeps_req0", 256'(fflags_acc[4:0]), 256'(5'b00100));
        rand_data();
        do_txn(2'b01, 1, {$urandom, $urandom}, 5'b00010, 2'b01);
        check_val("clr_with_acc", 256'(fflags_acc[4:0]), 256'(5'b00010));

        // Watchdog abort, then a completion arriving after the abort
        rand_data();
        do_txn(2'b01, -1, 64'hDEAD_BEEF, 5'b11111, '0);
        rand_data();
        do_txn(2'b10, TIMEOUT + 2, 64'hDEAD_BEEF, 5'b11111, '0);
        rand_data();
        do_txn(2'b01, TIMEOUT + 1, 64'hDEAD_BEEF, 5'b11111, '0);
        rand_data();
        do_txn(2'b10, TIMEOUT, 64'h1111_2222, 5'b01000, '0);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            rand_data();
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            sel  = $urandom_range(0, 9);
            if (sel <= 6)      lat = $urandom_range(0, 4);
            else if (sel == 7) lat = $urandom_range(5, TIMEOUT);
            else if (sel == 8) lat = -1;
            else               lat = TIMEOUT + $urandom_range(1, 2);
            clr = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            do_txn(mask, lat, {$urandom, $urandom}, 5'($urandom), clr);
        end

        // Reset while waiting on a divide
        rand_data();
        req_valid = 2'b01;
        #1;
        check_val("rw_grant", 256'(req_ready), 256'(oh((m_last + 1) % NREQ == 0 ? 0 : 0)) | 256'(req_ready & 2'b10));
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        model_reset();
        check_val("rw_busy", 256'(busy), 256'(0));
        check_val("rw_rsp", 256'(rsp_valid), 256'(0));
        check_val("rw_enable", 256'(exe_enable), 256'(0));
        check_val("rw_acc", 256'(fflags_acc), 256'(0));
        tick();
        exe_ready  = 1'b1;
        exe_result = {$urandom, $urandom};
        exe_flags  = 5'b11111;
        #1;
        check_val("rw_late_rsp", 256'(rsp_valid), 256'(0));
        tick();
        exe_ready = 1'b0;
        #1;
        check_val("rw_late_rsp2", 256'(rsp_valid), 256'(0));
        check_val("rw_late_busy", 256'(busy), 256'(0));
        check_val("rw_late_acc", 256'(fflags_acc), 256'(0));
        rand_data();
        do_txn(2'b11, 3, {$urandom, $urandom}, 5'b00001, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
